// File: rtl/aig_response_misr.sv
// aig_response_misr
// Self-test harness for an 11-in/11-out combinational AIG benchmark netlist.
// An LFSR drives the netlist inputs. The netlist responses are compacted into
// a MISR signature. At the end of a run the signature is compared against a
// golden value.
//
// Ports
//   clk         rising-edge clock
//   rst_n       synchronous reset, active-low
//   start       one-cycle run request (honoured only in IDLE)
//   abort       cancels a run in progress (no done pulse)
//   seed        first pattern, latched on start (0 is replaced by 1)
//   n_patterns  number of patterns to apply, latched on start
//   golden      expected signature, latched on start
//   dut_x       registered pattern to the netlist inputs
//   dut_f       netlist outputs, combinational response to dut_x
//   busy        high while patterns are being applied
//   done        one-cycle completion pulse
//   pass        signature==golden; valid from done, held until next start
//   signature   MISR contents; final value held until next start
//
// Handshake: start is a single-cycle request with no ready. It is accepted
// only when busy=0 and done=0; otherwise it is dropped, not queued. Each
// accepted run ends in exactly one of three ways: a done pulse (with pass
// valid in that same cycle), an abort, or a reset. Abort and reset produce
// no pulse.
module aig_response_misr #(
  parameter int IN_W  = 11,
  parameter int OUT_W = 11,
  parameter int CNT_W = 16,
  parameter logic [IN_W-1:0]  LFSR_TAPS = 11'h500,
  parameter logic [OUT_W-1:0] MISR_POLY = 11'h005
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  input  logic [IN_W-1:0]  seed,
  input  logic [CNT_W-1:0] n_patterns,
  input  logic [OUT_W-1:0] golden,
  output logic [IN_W-1:0]  dut_x,
  input  logic [OUT_W-1:0] dut_f,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [OUT_W-1:0] signature
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [IN_W-1:0]  X_ONE   = IN_W'(1);

  state_t           state_q;
  state_t           state_d;
  logic [IN_W-1:0]  x_q;
  logic [OUT_W-1:0] misr_q;
  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] n_q;
  logic [OUT_W-1:0] golden_q;
  logic             pass_q;

  logic [IN_W-1:0]  x_next;
  logic [OUT_W-1:0] misr_next;
  logic             last_capture;

  // Fibonacci LFSR step and Galois MISR step
  assign x_next    = {x_q[IN_W-2:0], ^(x_q & LFSR_TAPS)};
  assign misr_next = {misr_q[OUT_W-2:0], 1'b0}
                   ^ (misr_q[OUT_W-1] ? MISR_POLY : '0)
                   ^ dut_f;

  // The count value in this cycle is the number of captures already taken.
  // The last capture is the one where that count equals n-1.
  assign last_capture = (count_q == (n_q - CNT_ONE));

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = (n_patterns == '0) ? S_DONE : S_RUN;
        end
      end
      S_RUN: begin
        // abort wins over a completion in the same cycle
        if (abort) begin
          state_d = S_IDLE;
        end else if (last_capture) begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      x_q      <= '0;
      misr_q   <= '0;
      count_q  <= '0;
      n_q      <= '0;
      golden_q <= '0;
      pass_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      case (state_q)
        S_IDLE: begin
          if (start) begin
            n_q      <= n_patterns;
            golden_q <= golden;
            misr_q   <= '0;
            pass_q   <= 1'b0;
            count_q  <= '0;
            // an all-zero LFSR state would never leave zero
            if (n_patterns != '0) begin
              x_q <= (seed == '0) ? X_ONE : seed;
            end
          end
        end
        S_RUN: begin
          if (abort) begin
            pass_q <= 1'b0;
          end else begin
            misr_q  <= misr_next;
            x_q     <= x_next;
            count_q <= count_q + CNT_ONE;
          end
        end
        S_DONE: begin
          pass_q <= (misr_q == golden_q);
        end
        default: begin
          pass_q <= 1'b0;
        end
      endcase
    end
  end

  assign dut_x     = x_q;
  assign signature = misr_q;
  assign busy      = (state_q == S_RUN);
  assign done      = (state_q == S_DONE);
  // In the done cycle the comparison is presented directly. After that the
  // registered copy holds it until the next start.
  assign pass      = done ? (misr_q == golden_q) : pass_q;

endmodule

// File: tb/tb_aig_response_misr.sv
// Directed bench for aig_response_misr. The netlist is replaced by either a
// tied constant or a dut_f=dut_x loopback. Expected values are hand-computed
// from the LFSR/MISR recurrences.
module tb_aig_response_misr;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        abort;
  logic [10:0] seed;
  logic [15:0] n_patterns;
  logic [10:0] golden;
  logic [10:0] dut_x;
  logic [10:0] dut_f;
  logic        busy;
  logic        done;
  logic        pass;
  logic [10:0] signature;

  logic        f_loop;
  logic [10:0] f_const;

  int checks;
  int failures;

  assign dut_f = f_loop ? dut_x : f_const;

  aig_response_misr dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .abort      (abort),
    .seed       (seed),
    .n_patterns (n_patterns),
    .golden     (golden),
    .dut_x      (dut_x),
    .dut_f      (dut_f),
    .busy       (busy),
    .done       (done),
    .pass       (pass),
    .signature  (signature)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // driver tasks
  // Leaves the bench #1 into cycle 1 (the start edge is edge 0).
  task automatic start_run(input logic [10:0] s, input logic [15:0] n,
                           input logic [10:0] g);
    @(posedge clk);
    #1;
    seed       = s;
    n_patterns = n;
    golden     = g;
    start      = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  // Counts negedges from cycle 1 until done is seen.
  task automatic wait_done(input int budget, output int cyc, output bit seen);
    cyc  = 0;
    seen = 1'b0;
    for (int i = 1; i <= budget; i++) begin
      @(negedge clk);
      if (done) begin
        cyc  = i;
        seen = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if (dut_x !== 11'h000) begin
      failures++; $display("FAIL reset_dut_x got=%h exp=000", dut_x);
    end
    checks++;
    if (signature !== 11'h000) begin
      failures++; $display("FAIL reset_signature got=%h exp=000", signature);
    end
    checks++;
    if ({busy, done, pass} !== 3'b000) begin
      failures++; $display("FAIL reset_flags got=%b exp=000", {busy, done, pass});
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic test_single;
    int cyc;
    bit seen;
    f_loop  = 1'b0;
    f_const = 11'h7FF;
    start_run(11'h005, 16'd1, 11'h7FF);
    wait_done(10, cyc, seen);
    checks++;
    if (!seen || cyc != 2) begin
      failures++; $display("FAIL single_latency got=%0d seen=%0d exp=2", cyc, seen);
    end
    checks++;
    if (signature !== 11'h7FF) begin
      failures++; $display("FAIL single_signature got=%h exp=7ff", signature);
    end
    checks++;
    if (pass !== 1'b1 || busy !== 1'b0) begin
      failures++; $display("FAIL single_pass got=%b busy=%b exp=1 busy=0", pass, busy);
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b0 || pass !== 1'b1 || signature !== 11'h7FF) begin
      failures++;
      $display("FAIL single_hold got done=%b pass=%b sig=%h exp done=0 pass=1 sig=7ff",
               done, pass, signature);
    end
  endtask

  task automatic test_fail_sig;
    int cyc;
    bit seen;
    f_loop  = 1'b0;
    f_const = 11'h001;
    start_run(11'h007, 16'd2, 11'h004);
    wait_done(10, cyc, seen);
    checks++;
    if (!seen || cyc != 3) begin
      failures++; $display("FAIL fail_latency got=%0d seen=%0d exp=3", cyc, seen);
    end
    checks++;
    if (signature !== 11'h003 || pass !== 1'b0) begin
      failures++; $display("FAIL fail_sig got sig=%h pass=%b exp sig=003 pass=0", signature, pass);
    end
  endtask

  task automatic test_zero;
    f_loop  = 1'b0;
    f_const = 11'h7FF;
    start_run(11'h009, 16'd0, 11'h000);
    @(negedge clk);
    checks++;
    if (done !== 1'b1 || busy !== 1'b0) begin
      failures++; $display("FAIL zero_done got done=%b busy=%b exp done=1 busy=0", done, busy);
    end
    checks++;
    if (signature !== 11'h000 || pass !== 1'b1) begin
      failures++; $display("FAIL zero_sig got sig=%h pass=%b exp sig=000 pass=1", signature, pass);
    end
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      failures++; $display("FAIL zero_after got busy=%b done=%b exp 0 0", busy, done);
    end
  endtask

  task automatic test_lfsr_loopback;
    logic [10:0] exp_x [3];
    exp_x[0] = 11'h001;
    exp_x[1] = 11'h002;
    exp_x[2] = 11'h004;
    f_loop = 1'b1;
    start_run(11'h000, 16'd3, 11'h004);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (dut_x !== exp_x[i] || busy !== 1'b1) begin
        failures++;
        $display("FAIL lfsr_x[%0d] got=%h busy=%b exp=%h busy=1", i, dut_x, busy, exp_x[i]);
      end
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b1 || signature !== 11'h004 || pass !== 1'b1) begin
      failures++;
      $display("FAIL lfsr_sig got done=%b sig=%h pass=%b exp done=1 sig=004 pass=1",
               done, signature, pass);
    end
    f_loop = 1'b0;
  endtask

  // Exercises the LFSR tap feedback and the MISR polynomial feedback.
  task automatic test_feedback;
    logic [10:0] exp_x [4];
    exp_x[0] = 11'h500;
    exp_x[1] = 11'h200;
    exp_x[2] = 11'h400;
    exp_x[3] = 11'h001;
    f_loop  = 1'b0;
    f_const = 11'h400;
    start_run(11'h500, 16'd4, 11'h41B);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checks++;
      if (dut_x !== exp_x[i]) begin
        failures++; $display("FAIL fb_x[%0d] got=%h exp=%h", i, dut_x, exp_x[i]);
      end
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b1 || signature !== 11'h41B || pass !== 1'b1) begin
      failures++;
      $display("FAIL fb_sig got done=%b sig=%h pass=%b exp done=1 sig=41b pass=1",
               done, signature, pass);
    end
  endtask

  task automatic test_abort;
    int done_seen;
    f_loop  = 1'b0;
    f_const = 11'h7FF;
    start_run(11'h003, 16'd100, 11'h000);
    repeat (9) @(posedge clk);
    #1;
    abort = 1'b1;
    @(negedge clk);
    checks++;
    if (busy !== 1'b1 || signature !== 11'h557 || dut_x !== 11'h603) begin
      failures++;
      $display("FAIL abort_pre got busy=%b sig=%h x=%h exp busy=1 sig=557 x=603",
               busy, signature, dut_x);
    end
    @(posedge clk);
    #1;
    abort = 1'b0;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || pass !== 1'b0) begin
      failures++;
      $display("FAIL abort_flags got busy=%b done=%b pass=%b exp 0 0 0", busy, done, pass);
    end
    checks++;
    if (signature !== 11'h557 || dut_x !== 11'h603) begin
      failures++; $display("FAIL abort_hold got sig=%h x=%h exp sig=557 x=603", signature, dut_x);
    end
    done_seen = 0;
    repeat (5) begin
      @(negedge clk);
      if (done) done_seen++;
    end
    checks++;
    if (done_seen != 0) begin
      failures++; $display("FAIL abort_no_done got=%0d exp=0", done_seen);
    end
  endtask

  task automatic test_back_to_back;
    int cyc;
    bit seen;
    f_loop  = 1'b0;
    f_const = 11'h7FF;
    start_run(11'h001, 16'd1, 11'h7FF);
    wait_done(10, cyc, seen);
    checks++;
    if (!seen || cyc != 2) begin
      failures++; $display("FAIL b2b_latency got=%0d seen=%0d exp=2", cyc, seen);
    end
    // start presented in the done cycle must be dropped
    n_patterns = 16'd5;
    start      = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || pass !== 1'b1 || signature !== 11'h7FF) begin
      failures++;
      $display("FAIL b2b_ignored got busy=%b done=%b pass=%b sig=%h exp 0 0 1 7ff",
               busy, done, pass, signature);
    end
    @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin
      failures++; $display("FAIL b2b_not_queued got busy=%b exp=0", busy);
    end
  endtask

  task automatic test_reset_mid;
    int done_seen;
    f_loop  = 1'b0;
    f_const = 11'h7FF;
    start_run(11'h001, 16'd50, 11'h000);
    @(posedge clk);
    #1;
    n_patterns = 16'd1;
    start      = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    @(negedge clk);
    checks++;
    if (busy !== 1'b1 || signature !== 11'h004) begin
      failures++; $display("FAIL run_start_ignored got busy=%b sig=%h exp busy=1 sig=004", busy, signature);
    end
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if ({busy, done, pass} !== 3'b000 || dut_x !== 11'h000 || signature !== 11'h000) begin
      failures++;
      $display("FAIL midrst got flags=%b x=%h sig=%h exp 000 000 000",
               {busy, done, pass}, dut_x, signature);
    end
    done_seen = 0;
    repeat (6) begin
      @(negedge clk);
      if (done || busy) done_seen++;
    end
    checks++;
    if (done_seen != 0) begin
      failures++; $display("FAIL midrst_quiet got=%0d exp=0", done_seen);
    end
  endtask

  initial begin
    checks     = 0;
    failures   = 0;
    rst_n      = 1'b0;
    start      = 1'b0;
    abort      = 1'b0;
    seed       = '0;
    n_patterns = '0;
    golden     = '0;
    f_loop     = 1'b0;
    f_const    = '0;

    test_reset;
    test_single;
    test_fail_sig;
    test_zero;
    test_lfsr_loopback;
    test_feedback;
    test_abort;
    test_single;
    test_back_to_back;
    test_reset_mid;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
